// File: rtl/ddr_rx_target.sv
// HDR-DDR target receive stage: samples SDA on SCL edges in the mode chosen by the
// target engine and returns completion, preamble, error and deserialized bytes.
module ddr_rx_target #(
    parameter logic [4:0] CRC_SEED  = 5'h1F,
    parameter logic [3:0] TOKEN_VAL = 4'hC
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_rx_en,
    input  logic [3:0] i_rx_mode,
    input  logic       i_sda,
    input  logic       i_scl_pos_edge,
    input  logic       i_scl_neg_edge,
    output logic       o_rx_mode_done,
    output logic       o_rx_pre,
    output logic       o_rx_error,
    output logic       o_rx_ddrccc_rnw,
    output logic [7:0] o_rx_data,
    output logic [6:0] o_rx_addr
);

    typedef enum logic [3:0] {
        MODE_INIT   = 4'd0,
        MODE_PRE    = 4'd1,
        MODE_DATA   = 4'd2,
        MODE_CCC    = 4'd3,
        MODE_PARITY = 4'd4,
        MODE_TOKEN  = 4'd5,
        MODE_CRC    = 4'd6,
        MODE_ADDR   = 4'd7,
        MODE_ZEROS  = 4'd8,
        MODE_SPRE   = 4'd9
    } mode_e;

    // CRC5, polynomial x^5 + x^2 + 1, one byte MSB first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] seed, input logic [7:0] b);
        logic [4:0] c;
        c = seed;
        for (int i = 7; i >= 0; i--) begin
            c = {c[3:0], 1'b0} ^ ({5{c[4] ^ b[i]}} & 5'b00101);
        end
        return c;
    endfunction

    mode_e       mode;
    logic [3:0]  mode_q;
    logic [3:0]  bit_cnt;
    logic [3:0]  eff_cnt;
    logic [3:0]  need;
    logic [6:0]  shreg;
    logic [7:0]  shift_nxt;
    logic [15:0] word;
    logic [4:0]  crc;
    logic [1:0]  par_exp;
    logic        init_seen;
    logic        sample;
    logic        last;

    assign mode = mode_e'(i_rx_mode);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        need = 4'd0;
        case (mode)
            MODE_PRE:                                  need = 4'd1;
            MODE_SPRE, MODE_PARITY:                    need = 4'd2;
            MODE_TOKEN:                                need = 4'd4;
            MODE_CRC:                                  need = 4'd5;
            MODE_DATA, MODE_CCC, MODE_ADDR, MODE_ZEROS: need = 4'd8;
            default:                                   need = 4'd0;
        endcase
        // A mode change discards any partially collected bits.
        eff_cnt   = (i_rx_mode != mode_q) ? 4'd0 : bit_cnt;
        sample    = (i_scl_pos_edge | i_scl_neg_edge) & i_rx_en;
        shift_nxt = (eff_cnt == 4'd0) ? {7'd0, i_sda} : {shreg, i_sda};
        last      = sample && (need != 4'd0) && (eff_cnt + 4'd1 == need);
        par_exp   = {^(word & 16'hAAAA), ~^(word & 16'h5555)};
    end

    // NOTE: sequential state uses non-blocking assignments; later ones in the block override earlier ones.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            o_rx_mode_done  <= 1'b0;
            o_rx_pre        <= 1'b0;
            o_rx_error      <= 1'b0;
            o_rx_ddrccc_rnw <= 1'b0;
            o_rx_data       <= 8'd0;
            o_rx_addr       <= 7'd0;
            mode_q          <= 4'd0;
            bit_cnt         <= 4'd0;
            shreg           <= 7'd0;
            word            <= 16'd0;
            crc             <= CRC_SEED;
            init_seen       <= 1'b0;
        end else begin
            mode_q         <= i_rx_mode;
            o_rx_mode_done <= 1'b0;
            if (!i_rx_en) begin
                bit_cnt   <= 4'd0;
                init_seen <= 1'b0;
            end else if (mode == MODE_INIT) begin
                bit_cnt <= 4'd0;
                if (!init_seen) begin
                    init_seen      <= 1'b1;
                    o_rx_mode_done <= 1'b1;
                    crc            <= CRC_SEED;
                    word           <= 16'd0;
                    o_rx_error     <= 1'b0;
                end
            end else begin
                init_seen <= 1'b0;
                if (need == 4'd0) begin
                    bit_cnt <= 4'd0;
                end else if (sample) begin
                    shreg <= shift_nxt[6:0];
                    if (eff_cnt == 4'd0) o_rx_error <= 1'b0;
                    if (last) begin
                        bit_cnt        <= 4'd0;
                        o_rx_mode_done <= 1'b1;
                        case (mode)
                            MODE_PRE: o_rx_pre <= shift_nxt[0];
                            MODE_SPRE: begin
                                o_rx_pre   <= shift_nxt[0];
                                o_rx_error <= ~shift_nxt[1];
                            end
                            MODE_DATA, MODE_CCC: begin
                                o_rx_data <= shift_nxt;
                                word      <= {word[7:0], shift_nxt};
                                crc       <= crc5_byte(crc, shift_nxt);
                                if (mode == MODE_CCC) o_rx_ddrccc_rnw <= shift_nxt[7];
                            end
                            MODE_ADDR: begin
                                o_rx_addr <= shift_nxt[7:1];
                                word      <= {word[7:0], shift_nxt};
                                crc       <= crc5_byte(crc, shift_nxt);
                            end
                            MODE_ZEROS:  o_rx_error <= |shift_nxt;
                            MODE_PARITY: o_rx_error <= (shift_nxt[1:0] != par_exp);
                            MODE_TOKEN:  o_rx_error <= (shift_nxt[3:0] != TOKEN_VAL);
                            MODE_CRC:    o_rx_error <= (shift_nxt[4:0] != crc);
                            default: ;
                        endcase
                    end else begin
                        bit_cnt <= eff_cnt + 4'd1;
                    end
                end else begin
                    bit_cnt <= eff_cnt;
                end
            end
        end
    end

endmodule
